// File: rtl/serial_add_controller.sv
// Bit-serial adder sequencer: drives one external full adder LSB first, WIDTH cycles per add.
// START accepted at edge k gives RUN for k+1..k+WIDTH and DONE in k+WIDTH+1; START is ignored outside IDLE.
module serial_add_controller #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CIN,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_C,
  input  logic             FA_SUM,
  input  logic             FA_COUT,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_shift_q, sum_shift_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_shift_d = sum_shift_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A_IN;
          b_d     = B_IN;
          carry_d = CIN;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_shift_d = {FA_SUM, sum_shift_q[WIDTH-1:1]};
        carry_d     = FA_COUT;
        a_d         = a_q >> 1;
        b_d         = b_q >> 1;
        cnt_d       = cnt_q + CNT_W'(1);
        // The last bit lands straight in the result registers on the edge into FINISH.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {FA_SUM, sum_shift_q[WIDTH-1:1]};
          cout_d  = FA_COUT;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_shift_q <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_shift_q <= sum_shift_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  // Adder inputs come from registers only, so there is no loop through the external adder.
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_FINISH);
  assign FA_A = BUSY & a_q[0];
  assign FA_B = BUSY & b_q[0];
  assign FA_C = BUSY & carry_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_serial_add_controller.sv
// Randomized and directed bench for serial_add_controller with a behavioural full adder.
module tb_serial_add_controller;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin;
  logic         fa_a, fa_b, fa_c, fa_sum, fa_cout;
  logic [W-1:0] sum;
  logic         cout, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign fa_sum  = fa_a ^ fa_b ^ fa_c;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_add_controller #(.WIDTH(W)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .START(start),
    .A_IN(a_in), .B_IN(b_in), .CIN(cin),
    .FA_A(fa_a), .FA_B(fa_b), .FA_C(fa_c),
    .FA_SUM(fa_sum), .FA_COUT(fa_cout),
    .SUM(sum), .COUT(cout), .BUSY(busy), .DONE(done)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fa"}, 32'({fa_a, fa_b, fa_c}), 0);
  endtask

  // Full addition from IDLE; optionally scribbles on the operand inputs while running.
  task automatic do_add(input int a, input int b, input int c, input bit scramble);
    int exp_total, d0, mask;
    exp_total = a + b + c;
    d0 = done_cnt;
    start = 1'b1; a_in = W'(a); b_in = W'(b); cin = c[0];
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      mask = (1 << i) - 1;
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      chk("fa_a", 32'(fa_a), (a >> i) & 1);
      chk("fa_b", 32'(fa_b), (b >> i) & 1);
      chk("fa_c", 32'(fa_c), (((a & mask) + (b & mask) + c) >> i) & 1);
      if (scramble) begin
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
        start = 1'($urandom);
      end
      tick();
      start = 1'b0;
    end
    chk("fin_done", 32'(done), 1);
    chk("fin_busy", 32'(busy), 0);
    chk("sum", 32'(sum), exp_total % (1 << W));
    chk("cout", 32'(cout), (exp_total >> W) & 1);
    tick();
    chk_idle("post");
    chk("done_once", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0, starts;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_sum", 32'(sum), 0);
    chk("reset_cout", 32'(cout), 0);
    rst_n = 1'b1;
    tick();

    do_add(5, 3, 0, 0);
    do_add(15, 1, 0, 0);
    do_add(15, 15, 1, 0);

    // Busy rejection: START pulses during RUN and FINISH, operands change mid-run.
    d0 = done_cnt;
    start = 1'b1; a_in = 2; b_in = 2; cin = 0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a_in = 7; b_in = 7; cin = 1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rej_done", 32'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_sum", 32'(sum), 4);
    chk("rej_cout", 32'(cout), 0);
    chk_idle("rej_idle");
    tick();
    chk_idle("rej_norestart");
    chk("rej_done_cnt", 32'(done_cnt - d0), 1);

    // Back-to-back with START held.
    d0 = done_cnt;
    start = 1'b1; a_in = 3; b_in = 4; cin = 0;
    for (int r = 0; r < 3; r++) begin
      chk_idle("b2b_idle");
      tick();
      for (int i = 0; i < W; i++) begin
        chk("b2b_busy", 32'(busy), 1);
        tick();
      end
      chk("b2b_done", 32'(done), 1);
      chk("b2b_sum", 32'(sum), 7);
      tick();
    end
    start = 1'b0;
    tick();
    chk("b2b_done_cnt", 32'(done_cnt - d0), 3);

    // Reset mid-run: 9+6 aborted after two RUN cycles.
    d0 = done_cnt;
    start = 1'b1; a_in = 9; b_in = 6; cin = 0;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("abort");
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    for (int i = 0; i < W + 2; i++) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    do_add(1, 1, 0, 0);

    // Exhaustive sweep.
    d0 = done_cnt;
    starts = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          do_add(a, b, c, 0);
          starts++;
        end
    chk("sweep_done_cnt", 32'(done_cnt - d0), 32'(starts));
    chk("sweep_count", 32'(starts), 512);

    // Random operands with random input churn while busy.
    for (int n = 0; n < 40; n++)
      do_add(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
